// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_arb_pkg
// Shared types and sizing helpers for the FIFO write-side arbiter and any
// other arbiter that reuses the round-robin picker.
//   arb_state_e   : grant FSM states (idle / burst in progress)
//   N_DEF, DATA_DEF, MAXB_DEF : default requester count, data width, burst cap
//   OWNER_W_DEF, CNT_W_DEF    : widths of owner index and beat counter at defaults
//   ownerWidth(), cntWidth()  : the same widths for any parameterisation
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int N_DEF    = 4;
  localparam int DATA_DEF = 8;
  localparam int MAXB_DEF = 4;

  // Owner index needs at least one bit even though N is never below 2.
  function automatic int ownerWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Beat counter must be able to hold MAXB itself, hence MAXB+1 values.
  function automatic int cntWidth(input int maxb);
    return (maxb < 1) ? 1 : $clog2(maxb + 1);
  endfunction

  localparam int OWNER_W_DEF = ownerWidth(N_DEF);
  localparam int CNT_W_DEF   = cntWidth(MAXB_DEF);

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if
// Bundles the requester side and the FIFO write port of the arbiter.
//   req, last, din : per-requester beat valid, final-beat marker, data slices
//   full           : FIFO full flag (write-clock domain)
//   ack            : one-hot beat-accepted strobe back to the requesters
//   w_en, wdata    : FIFO write enable and data
//   owner, busy    : current grant holder and grant-active flag
// Modport master is the arbiter's view; slave is the environment's view.
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DATA = DATA_DEF
);

  localparam int OW = ownerWidth(N);

  logic [N-1:0]      req;
  logic [N-1:0]      last;
  logic [N*DATA-1:0] din;
  logic              full;
  logic [N-1:0]      ack;
  logic              w_en;
  logic [DATA-1:0]   wdata;
  logic [OW-1:0]     owner;
  logic              busy;

  modport master (
    input  req, last, din, full,
    output ack, w_en, wdata, owner, busy
  );

  modport slave (
    output req, last, din, full,
    input  ack, w_en, wdata, owner, busy
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker: returns the first set request bit at or
// after ptr, scanning upward and wrapping past N-1 back to 0.
//   req : request vector
//   ptr : starting position of the scan (must be below N)
//   idx : chosen index (0 when nothing is requested)
//   any : at least one request is set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int IW = ownerWidth(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam int CW = IW + 1;

  logic [CW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester at or
  // after ptr is the last writer and therefore wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N)) begin
        cand = cand - CW'(N);
      end
      if (req[cand[IW-1:0]]) begin
        idx = cand[IW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Shares the single FIFO write port among N requesters. A grant is given in
// round-robin order and covers up to MAXB beats; it ends early on the owner's
// last flag or when the owner withdraws its request while the FIFO is not full.
// Each grant is followed by one idle cycle before the next one.
//   wclk : write-domain clock
//   wrst : asynchronous active-low reset
//   bus  : requester handshake and FIFO write port (master modport)
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DATA = DATA_DEF,
  parameter int MAXB = MAXB_DEF
) (
  input  logic                 wclk,
  input  logic                 wrst,
  fifo_write_arbiter_if.master bus
);

  localparam int IW = ownerWidth(N);
  localparam int CW = cntWidth(MAXB);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rrPtr_q, rrPtr_d;
  logic [CW-1:0]   beatCnt_q, beatCnt_d;
  logic [CW-1:0]   beatNext;
  logic [IW-1:0]   pickIdx;
  logic            pickAny;
  logic            endGrant;
  logic [IW-1:0]   ptrAfterOwner;
  logic [DATA-1:0] ownerData;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req (bus.req),
    .ptr (rrPtr_q),
    .idx (pickIdx),
    .any (pickAny)
  );

  assign beatNext      = beatCnt_q + 1'b1;
  assign ptrAfterOwner = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

  // Data slice of the current owner; only reaches wdata on an accepted beat.
  always_comb begin
    ownerData = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == IW'(i)) begin
        ownerData = bus.din[i*DATA +: DATA];
      end
    end
  end

  // State registers; reset drops any grant in flight so w_en/ack/wdata
  // fall to zero as soon as wrst goes low.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      rrPtr_q   <= '0;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rrPtr_q   <= rrPtr_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  // Grant FSM and write-port drive. While full is high nothing moves, so a
  // request withdrawal is only acted on once the FIFO has room again.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rrPtr_d   = rrPtr_q;
    beatCnt_d = beatCnt_q;
    endGrant  = 1'b0;
    bus.w_en  = 1'b0;
    bus.ack   = '0;
    bus.wdata = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pickAny) begin
          state_d   = ARB_BURST;
          owner_d   = pickIdx;
          beatCnt_d = '0;
        end
      end
      ARB_BURST: begin
        if (!bus.full) begin
          if (bus.req[owner_q]) begin
            bus.w_en         = 1'b1;
            bus.ack[owner_q] = 1'b1;
            bus.wdata        = ownerData;
            beatCnt_d        = beatNext;
            if (bus.last[owner_q] || (beatNext == CW'(MAXB))) begin
              endGrant = 1'b1;
            end
          end else begin
            endGrant = 1'b1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (endGrant) begin
      state_d = ARB_IDLE;
      rrPtr_d = ptrAfterOwner;
    end
  end

  assign bus.busy  = (state_q == ARB_BURST);
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
// Self-checking bench for fifo_write_arbiter with N=4, DATA=8, MAXB=4.
// Directed scenarios check the required grant/beat timelines against fixed
// expectations; a randomized run compares every cycle against a behavioural
// model of the grant rules kept in this file.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int N    = 4;
  localparam int DATA = 8;
  localparam int MAXB = 4;

  logic wclk = 1'b0;
  logic wrst = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model state
  bit mBusy;
  int mOwner;
  int mPtr;
  int mCnt;

  // Expected and observed outputs of the most recent cycle
  logic       expWen, expBusy;
  logic [3:0] expAck;
  logic [7:0] expData;
  logic [1:0] expOwner;
  logic       obsWen, obsBusy;
  logic [3:0] obsAck;
  logic [7:0] obsData;
  logic [1:0] obsOwner;

  fifo_write_arbiter_if #(.N(N), .DATA(DATA)) bus ();

  fifo_write_arbiter #(
    .N    (N),
    .DATA (DATA),
    .MAXB (MAXB)
  ) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  // Reset DUT and model; returns one cycle after release, #1 past the edge.
  task automatic doReset();
    wrst     = 1'b0;
    bus.req  = '0;
    bus.last = '0;
    bus.full = 1'b0;
    bus.din  = '0;
    mBusy    = 0;
    mOwner   = 0;
    mPtr     = 0;
    mCnt     = 0;
    @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b1;
    @(posedge wclk);
    #1;
  endtask

  // One clock cycle: apply inputs, sample at the falling edge, predict the
  // outputs from the model, then advance the model at the rising edge.
  task automatic tick(input logic [3:0] r, input logic [3:0] l,
                      input logic f, input logic [31:0] d);
    bit beat;
    bus.req  = r;
    bus.last = l;
    bus.full = f;
    bus.din  = d;
    @(negedge wclk);
    obsWen   = bus.w_en;
    obsAck   = bus.ack;
    obsData  = bus.wdata;
    obsBusy  = bus.busy;
    obsOwner = bus.owner;
    beat     = mBusy && r[mOwner] && !f;
    expBusy  = mBusy;
    expOwner = mOwner[1:0];
    expWen   = beat;
    expAck   = beat ? (4'b0001 << mOwner) : 4'b0000;
    expData  = beat ? d[mOwner*8 +: 8] : 8'h00;
    @(posedge wclk);
    if (!mBusy) begin
      for (int k = 0; k < N; k++) begin
        if (!mBusy && r[(mPtr + k) % N]) begin
          mBusy  = 1;
          mOwner = (mPtr + k) % N;
          mCnt   = 0;
        end
      end
    end else if (!f) begin
      if (r[mOwner]) begin
        mCnt++;
        if (l[mOwner] || mCnt == MAXB) begin
          mBusy = 0;
          mPtr  = (mOwner + 1) % N;
        end
      end else begin
        mBusy = 0;
        mPtr  = (mOwner + 1) % N;
      end
    end
    #1;
  endtask

  // Reset values, asynchronous reset in the middle of a burst, and the
  // round-robin pointer restarting at requester 0 afterwards.
  task automatic test_reset();
    doReset();
    checkCount++;
    if ({bus.w_en, bus.ack, bus.wdata, bus.busy, bus.owner} !== '0)
      $display("[TB] FAIL reset_values got w_en=%b ack=%b wdata=%h busy=%b owner=%0d want all 0",
               bus.w_en, bus.ack, bus.wdata, bus.busy, bus.owner);
    else passCount++;

    tick(4'b0010, 4'b0000, 1'b0, 32'h0000_1100);
    checkCount++;
    if (obsBusy !== 1'b0 || obsWen !== 1'b0)
      $display("[TB] FAIL grant_cycle got busy=%b w_en=%b want busy=0 w_en=0", obsBusy, obsWen);
    else passCount++;

    tick(4'b0010, 4'b0000, 1'b0, 32'h0000_1100);
    checkCount++;
    if (obsWen !== 1'b1 || obsAck !== 4'b0010 || obsData !== 8'h11 || obsOwner !== 2'd1)
      $display("[TB] FAIL first_beat got w_en=%b ack=%b wdata=%h owner=%0d want 1 0010 11 1",
               obsWen, obsAck, obsData, obsOwner);
    else passCount++;

    bus.din = 32'h0000_1200;
    #2;
    wrst = 1'b0;
    #1;
    checkCount++;
    if ({bus.w_en, bus.ack, bus.wdata, bus.busy, bus.owner} !== '0)
      $display("[TB] FAIL async_reset got w_en=%b ack=%b wdata=%h busy=%b owner=%0d want all 0",
               bus.w_en, bus.ack, bus.wdata, bus.busy, bus.owner);
    else passCount++;
    mBusy   = 0;
    mOwner  = 0;
    mPtr    = 0;
    mCnt    = 0;
    bus.req = '0;
    @(negedge wclk);
    wrst = 1'b1;
    @(posedge wclk);
    #1;
    checkCount++;
    if (bus.busy !== 1'b0)
      $display("[TB] FAIL busy_after_release got %b want 0", bus.busy);
    else passCount++;

    tick(4'b1111, 4'b1111, 1'b0, 32'h4433_2211);
    tick(4'b1111, 4'b1111, 1'b0, 32'h4433_2211);
    checkCount++;
    if (obsOwner !== 2'd0 || obsAck !== 4'b0001 || obsData !== 8'h11)
      $display("[TB] FAIL ptr_after_reset got owner=%0d ack=%b wdata=%h want 0 0001 11",
               obsOwner, obsAck, obsData);
    else passCount++;
  endtask

  // All four requesting single-beat bursts: grants 0,1,2,3,0 with one idle
  // cycle between them.
  task automatic test_round_robin();
    logic       wantWen;
    logic [3:0] wantAck;
    logic [7:0] wantData;
    doReset();
    for (int t = 0; t < 10; t++) begin
      tick(4'b1111, 4'b1111, 1'b0, 32'hD3D2_D1D0);
      wantWen  = (t % 2) == 1;
      wantAck  = wantWen ? (4'b0001 << ((t / 2) % 4)) : 4'b0000;
      wantData = wantWen ? 8'(8'hD0 + (t / 2) % 4) : 8'h00;
      checkCount++;
      if (obsWen !== wantWen || obsAck !== wantAck || obsData !== wantData || obsBusy !== wantWen)
        $display("[TB] FAIL round_robin_t%0d got w_en=%b ack=%b wdata=%h busy=%b want %b %b %h %b",
                 t, obsWen, obsAck, obsData, obsBusy, wantWen, wantAck, wantData, wantWen);
      else passCount++;
    end
  endtask

  // Requester 2 streams six beats without last: four beats, bubble,
  // re-grant, remaining two beats, then withdrawal.
  task automatic test_maxb_cap();
    int         idx;
    int         wcnt;
    logic [7:0] b;
    logic       wantW;
    logic [7:0] wantData;
    doReset();
    idx  = 0;
    wcnt = 0;
    for (int t = 0; t < 10; t++) begin
      b = 8'(8'hA0 + idx);
      tick((idx < 6) ? 4'b0100 : 4'b0000, 4'b0000, 1'b0, {8'h00, b, 16'h0000});
      wantW    = (t >= 1 && t <= 4) || t == 6 || t == 7;
      wantData = wantW ? 8'(8'hA0 + wcnt) : 8'h00;
      checkCount++;
      if (obsWen !== wantW || obsData !== wantData || obsAck !== (wantW ? 4'b0100 : 4'b0000)
          || obsBusy !== expBusy)
        $display("[TB] FAIL maxb_cap_t%0d got w_en=%b wdata=%h ack=%b busy=%b want %b %h busy=%b",
                 t, obsWen, obsData, obsAck, obsBusy, wantW, wantData, expBusy);
      else passCount++;
      if (wantW) wcnt++;
      if (obsAck[2]) idx++;
    end
  endtask

  // Full held for three cycles after the first beat: grant and beat count
  // must hold, so the cap still falls after the fourth written beat.
  task automatic test_full_stall();
    int         idx;
    int         wcnt;
    logic [7:0] b;
    logic       f;
    logic       wantW;
    logic       wantBusy;
    logic [7:0] wantData;
    doReset();
    idx  = 0;
    wcnt = 0;
    for (int t = 0; t < 11; t++) begin
      b = 8'(8'hB0 + idx);
      f = (t >= 2 && t <= 4);
      tick((idx < 5) ? 4'b0001 : 4'b0000, 4'b0000, f, {24'h000000, b});
      wantW    = t == 1 || (t >= 5 && t <= 7) || t == 9;
      wantBusy = !(t == 0 || t == 8);
      wantData = wantW ? 8'(8'hB0 + wcnt) : 8'h00;
      checkCount++;
      if (obsWen !== wantW || obsData !== wantData || obsAck !== {3'b000, wantW}
          || obsBusy !== wantBusy || obsOwner !== 2'd0)
        $display("[TB] FAIL full_stall_t%0d got w_en=%b wdata=%h ack=%b busy=%b owner=%0d want %b %h busy=%b owner=0",
                 t, obsWen, obsData, obsAck, obsBusy, obsOwner, wantW, wantData, wantBusy);
      else passCount++;
      if (wantW) wcnt++;
      if (obsAck[0]) idx++;
    end
  endtask

  // Requester 3 withdraws after one beat: no write, back to idle, and the
  // next grant scans from requester 0.
  task automatic test_abandon();
    doReset();
    tick(4'b1000, 4'b0000, 1'b0, 32'hC300_00C0);
    tick(4'b1000, 4'b0000, 1'b0, 32'hC300_00C0);
    checkCount++;
    if (obsWen !== 1'b1 || obsAck !== 4'b1000 || obsData !== 8'hC3)
      $display("[TB] FAIL abandon_first_beat got w_en=%b ack=%b wdata=%h want 1 1000 c3",
               obsWen, obsAck, obsData);
    else passCount++;
    tick(4'b0000, 4'b0000, 1'b0, 32'hC300_00C0);
    checkCount++;
    if (obsWen !== 1'b0 || obsAck !== 4'b0000 || obsBusy !== 1'b1)
      $display("[TB] FAIL abandon_no_write got w_en=%b ack=%b busy=%b want 0 0000 1",
               obsWen, obsAck, obsBusy);
    else passCount++;
    tick(4'b1001, 4'b1001, 1'b0, 32'hC300_00C0);
    checkCount++;
    if (obsBusy !== 1'b0 || obsWen !== 1'b0)
      $display("[TB] FAIL abandon_idle got busy=%b w_en=%b want 0 0", obsBusy, obsWen);
    else passCount++;
    tick(4'b1001, 4'b1001, 1'b0, 32'hC300_00C0);
    checkCount++;
    if (obsOwner !== 2'd0 || obsAck !== 4'b0001 || obsData !== 8'hC0)
      $display("[TB] FAIL abandon_regrant got owner=%0d ack=%b wdata=%h want 0 0001 c0",
               obsOwner, obsAck, obsData);
    else passCount++;
  endtask

  // Random requesters, last flags, withdrawals and full, checked each cycle
  // against the behavioural model.
  task automatic test_random();
    bit   [3:0] pend;
    bit   [3:0] lastb;
    logic [7:0] data [4];
    logic [31:0] d;
    logic        f;
    doReset();
    pend  = '0;
    lastb = '0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          data[i]  = 8'($urandom);
          lastb[i] = ($urandom_range(0, 2) == 0);
        end else if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
      end
      f = ($urandom_range(0, 3) == 0);
      d = {data[3], data[2], data[1], data[0]};
      tick(pend, lastb, f, d);
      checkCount++;
      if (obsWen !== expWen || obsAck !== expAck || obsData !== expData
          || obsBusy !== expBusy || obsOwner !== expOwner)
        $display("[TB] FAIL random_c%0d got w_en=%b ack=%b wdata=%h busy=%b owner=%0d want %b %b %h %b %0d",
                 c, obsWen, obsAck, obsData, obsBusy, obsOwner,
                 expWen, expAck, expData, expBusy, expOwner);
      else passCount++;
      for (int i = 0; i < 4; i++) begin
        if (obsAck[i]) pend[i] = 1'b0;
      end
    end
  endtask

  // Scenario sequence
  initial begin
    bus.req  = '0;
    bus.last = '0;
    bus.full = 1'b0;
    bus.din  = '0;
    test_reset();
    test_round_robin();
    test_maxb_cap();
    test_full_stall();
    test_abandon();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Write-side arbiter that shares the single write port of the asynchronous FIFO among N requesters in the `wclk` domain. It grants one requester at a time using round-robin order. Each grant covers a burst of up to MAXB beats and ends early on the requester's `last` flag. The block drives the FIFO's `w_en`/`wdata` directly and stalls on the FIFO `full` flag; the read side is unaffected.

## Interface
- `N`, 4: number of requesters (2..8)
- `DATA`, 8: data width; matches FIFO `DATA`
- `MAXB`, 4: maximum beats per grant (1..16)

Ports:
- `wclk`  in  1  write-domain clock; single clock for the whole block
- `wrst`  in  1  asynchronous, active-low reset
- `req`  in  N  per-requester beat valid; held until acked
- `last`  in  N  per-requester final-beat marker, qualified by `req`
- `din`  in  N*DATA  requester data; slice i is `din[i*DATA +: DATA]`
- `full`  in  1  FIFO full flag, registered in `wclk` domain
- `ack`  out  N  one-hot beat-accepted strobe
- `w_en`  out  1  FIFO write enable
- `wdata`  out  DATA  FIFO write data
- `owner`  out  $clog2(N)  index of current grant holder
- `busy`  out  1  a grant is active

## Operation
- FSM states:
  - IDLE: no grant.
  - BURST: `owner` holds the port.
- IDLE -> BURST when any `req` bit is set.
  - `owner` takes the first set bit at or after `rr_ptr`, scanning upward with wrap.
  - `beat_cnt` is cleared.
- In BURST, a beat transfers when `req[owner] && !full`. That cycle:
  - `w_en` = 1
  - `ack[owner]` = 1
  - `wdata` = `din` slice `owner`
  - `beat_cnt` increments.
- BURST -> IDLE on any of:
  - An accepted beat with `last[owner]` = 1.
  - An accepted beat that makes `beat_cnt` == MAXB.
  - `req[owner]` = 0 while `full` = 0 (abandon). No write occurs that cycle.
- On every exit, `rr_ptr` <= `owner` + 1, wrapping mod N.
- `full` = 1 in BURST stalls the burst. `beat_cnt` and the grant hold and no timeout applies. A `req[owner]` drop during full is ignored until `full` clears.
- `w_en`, `ack` and `wdata` are combinational from registered state plus `req`, `full` and `din`. `wdata` = 0 when `w_en` = 0.
- `beat_cnt` width is $clog2(MAXB+1). With MAXB = 1, every grant ends after one beat.
- Non-owner `req`/`last` are ignored. Their `ack` bits stay 0.

## Timing
- Reset (asserted asynchronously, any state):
  - State -> IDLE.
  - `rr_ptr`, `owner` and `beat_cnt` -> 0.
  - `busy` -> 0.
  - `w_en`, `ack` and `wdata` -> 0 immediately.
- Reset mid-burst discards the burst. No partial-write cleanup is done; FIFO contents belong to the FIFO's own reset.
- Grant latency: 1 cycle. `req` seen in IDLE at edge k gives `busy` = 1 after edge k. The first beat can be acked in cycle k+1.
- Back-to-back bursts: the exit edge returns to IDLE, so there is a 1-cycle bubble between grants, including a re-grant to the same requester.
- Throughput inside a burst is 1 beat/cycle while `req[owner]` = 1 and `full` = 0.
- A requester changes `din`/`last` only after the cycle in which its `ack` is high.

## Structure
- Package `fifo_arb_pkg`:
  - state enum: `ARB_IDLE`, `ARB_BURST`
  - width helper constants for `owner` and `beat_cnt`
  - default values of `N`, `DATA`, `MAXB`
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `idx`, `any`.
  - Reused by other arbiters in the design.
- Top level holds the FSM, `rr_ptr`, `beat_cnt` and the data mux.

## Test plan
- Reset mid-burst:
  - Stimulus: N=4, MAXB=4. Requester 1 drives 0x11..0x13 with `last` on 0x13. Assert `wrst` low on the second beat.
  - Required: all outputs 0 immediately. After release, `busy` = 0 and `rr_ptr` = 0.
- Round-robin with all requesting:
  - Stimulus: `req` = 4'b1111, every beat has `last`.
  - Required: grants go 0, 1, 2, 3, 0. There is 1 ack per grant and 1 idle cycle between grants.
- MAXB cap:
  - Stimulus: requester 2 streams 6 beats 0xA0..0xA5 with no `last`.
  - Required: 0xA0..0xA3 written, then IDLE. If no other request is pending, re-grant to 2; 0xA4 is written after a 1-cycle bubble.
- Full stall:
  - Stimulus: `full` = 1 for 3 cycles mid-burst.
  - Required: `w_en` = 0 and `ack` = 0 for those cycles, grant and `beat_cnt` unchanged. The pending beat is written on the first cycle with `full` = 0.
- Abandon:
  - Stimulus: requester 3 drops `req` after 1 beat, while `full` = 0.
  - Required: return to IDLE with no write. The next grant goes to 0 when `req` = 4'b1001.
